// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
//   Sequencing controller for the iterative CORDIC datapath. Accepts a job
//   over a valid/ready handshake, loads the x/y/z bank, runs n_q
//   micro-rotations (runtime count, clamped to MAX_ITER) and holds the final
//   result until the consumer takes it.
//
//   Handshakes: a transfer happens on a rising edge where valid && ready are
//   both high. The job source keeps in_valid and its payload stable until
//   in_ready. The controller keeps out_valid high, without any change, until
//   out_ready.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready job request handshake; in_mode, in_n_iter sampled on accept
//   abort             cancels the running job (blocks acceptance in IDLE)
//   y_msb, z_msb      datapath sign bits used for the direction decode
//   load_en, sel_fb   datapath load enable and input mux select (1 = feedback)
//   iter_en           datapath micro-rotation register enable
//   idx               iteration index (shift amount / atan LUT address)
//   dir               1 = d_i=+1, 0 = d_i=-1; forced 0 outside ITER
//   mode_q            latched mode (0 rotation, 1 vectoring)
//   busy              job in LOAD or ITER
//   out_valid/out_ready result hand-off handshake
//   state_dbg         current FSM state (IDLE=0, LOAD=1, ITER=2, DONE=3)

module cordic_iter_ctrl #(
    parameter int MAX_ITER = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [IDX_W:0]   in_n_iter,
    input  logic             abort,
    input  logic             y_msb,
    input  logic             z_msb,
    output logic             load_en,
    output logic             sel_fb,
    output logic             iter_en,
    output logic [IDX_W-1:0] idx,
    output logic             dir,
    output logic             mode_q,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [IDX_W:0]   MAX_N   = (IDX_W + 1)'(MAX_ITER);
    localparam logic [IDX_W:0]   ONE_N   = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

    state_t         state;
    logic [IDX_W:0] n_q;
    logic [IDX_W:0] n_clamp;
    logic           last_iter;

    // Zero and out-of-range requests both mean "full precision".
    always_comb begin
        n_clamp = in_n_iter;
        if (in_n_iter == '0 || in_n_iter > MAX_N)
            n_clamp = MAX_N;
    end

    // n_q is never 0 while in ITER, so n_q-1 cannot underflow there.
    assign last_iter = ({1'b0, idx} == (n_q - ONE_N));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            mode_q <= 1'b0;
            n_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    idx <= '0;
                    if (in_valid && !abort) begin
                        mode_q <= in_mode;
                        n_q    <= n_clamp;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    idx   <= '0;
                    state <= abort ? S_IDLE : S_ITER;
                end
                S_ITER: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (last_iter) begin
                        state <= S_DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + ONE_IDX;
                    end
                end
                S_DONE: begin
                    idx <= '0;
                    // abort together with out_ready is treated as an abort;
                    // both lead to IDLE so one condition covers them.
                    if (abort || out_ready)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        load_en   = 1'b0;
        sel_fb    = 1'b0;
        iter_en   = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        dir       = 1'b0;
        case (state)
            S_IDLE: in_ready = !abort;
            S_LOAD: begin
                load_en = 1'b1;
                busy    = 1'b1;
            end
            S_ITER: begin
                sel_fb  = 1'b1;
                iter_en = 1'b1;
                busy    = 1'b1;
                // Rotation drives z to 0, vectoring drives y to 0.
                dir     = mode_q ? y_msb : !z_msb;
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed self-checking bench for cordic_iter_ctrl (MAX_ITER=16).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.

module tb_cordic_iter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [4:0] in_n_iter;
    logic       abort;
    logic       y_msb;
    logic       z_msb;
    logic       load_en;
    logic       sel_fb;
    logic       iter_en;
    logic [3:0] idx;
    logic       dir;
    logic       mode_q;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    cordic_iter_ctrl #(.MAX_ITER(16), .IDX_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_n_iter (in_n_iter),
        .abort     (abort),
        .y_msb     (y_msb),
        .z_msb     (z_msb),
        .load_en   (load_en),
        .sel_fb    (sel_fb),
        .iter_en   (iter_en),
        .idx       (idx),
        .dir       (dir),
        .mode_q    (mode_q),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_dbg (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, in_ready, 1);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".load_en"}, load_en, 0);
        chk({tag, ".sel_fb"}, sel_fb, 0);
        chk({tag, ".iter_en"}, iter_en, 0);
        chk({tag, ".dir"}, dir, 0);
        chk({tag, ".idx"}, idx, 0);
    endtask

    // Full job: accept, LOAD, n_exp ITER cycles, DONE held 'hold' extra
    // cycles, hand-off, IDLE. y/z sign bits follow a per-iteration pattern.
    task automatic run_job(input logic mode, input logic [4:0] n_req,
                           input int n_exp, input int hold);
        logic exp_dir;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_n_iter = n_req;
        settle();
        chk("accept.in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_mode  = ~mode;
        z_msb    = 1'b0;
        y_msb    = 1'b1;
        settle();
        chk("load.load_en", load_en, 1);
        chk("load.sel_fb", sel_fb, 0);
        chk("load.busy", busy, 1);
        chk("load.idx", idx, 0);
        chk("load.dir", dir, 0);
        chk("load.mode_q", mode_q, mode);
        chk("load.in_ready", in_ready, 0);
        for (int i = 0; i < n_exp; i++) begin
            tick();
            z_msb = i[0];
            y_msb = i[1];
            exp_dir = mode ? i[1] : !i[0];
            settle();
            chk("iter.idx", idx, i);
            chk("iter.iter_en", iter_en, 1);
            chk("iter.sel_fb", sel_fb, 1);
            chk("iter.dir", dir, exp_dir);
            chk("iter.out_valid", out_valid, 0);
        end
        tick();
        z_msb = 1'b0;
        y_msb = 1'b1;
        settle();
        chk("done.out_valid", out_valid, 1);
        chk("done.iter_en", iter_en, 0);
        chk("done.load_en", load_en, 0);
        chk("done.dir", dir, 0);
        chk("done.in_ready", in_ready, 0);
        chk("done.busy", busy, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            tick();
            settle();
            chk("hold.out_valid", out_valid, 1);
            chk("hold.in_ready", in_ready, 0);
            chk("hold.iter_en", iter_en, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("handoff.out_valid", out_valid, 1);
        tick();
        out_ready = 1'b0;
        settle();
        chk_idle("after_handoff");
    endtask

    // Accept a job and advance to the ITER cycle where idx == stop_idx.
    task automatic start_to_idx(input logic [4:0] n_req, input int stop_idx);
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_n_iter = n_req;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i <= stop_idx; i++) tick();
        settle();
        chk("walk.idx", idx, stop_idx);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_n_iter = 5'd0;
        abort     = 1'b0;
        y_msb     = 1'b0;
        z_msb     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset.mode_q", mode_q, 0);
        reset = 1'b0;
        tick();

        // Basic rotation job, then vectoring job.
        run_job(1'b0, 5'd10, 10, 0);
        run_job(1'b1, 5'd6, 6, 0);

        // Clamping and minimum length.
        run_job(1'b0, 5'd0, 16, 0);
        run_job(1'b1, 5'd20, 16, 0);
        run_job(1'b0, 5'd1, 1, 0);
        run_job(1'b0, 5'd16, 16, 0);

        // Backpressure in DONE for 5 cycles with a pending request.
        run_job(1'b1, 5'd3, 3, 5);

        // Abort in ITER at idx=4: back to IDLE, no out_valid afterwards.
        start_to_idx(5'd10, 4);
        abort = 1'b1;
        settle();
        chk("abort_iter.in_ready", in_ready, 0);
        tick();
        abort = 1'b0;
        settle();
        chk_idle("abort_iter");
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("abort_iter.no_out_valid", out_valid, 0);
        end

        // Abort in IDLE blocks a request.
        abort    = 1'b1;
        in_valid = 1'b1;
        settle();
        chk("abort_idle.in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        settle();
        chk("abort_idle.load_en", load_en, 0);
        chk("abort_idle.busy", busy, 0);

        // Abort in LOAD.
        in_valid  = 1'b1;
        in_n_iter = 5'd5;
        tick();
        in_valid = 1'b0;
        abort    = 1'b1;
        settle();
        chk("abort_load.load_en", load_en, 1);
        tick();
        abort = 1'b0;
        settle();
        chk_idle("abort_load");

        // abort with out_ready in DONE.
        in_valid  = 1'b1;
        in_n_iter = 5'd1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        settle();
        chk("abort_done.out_valid", out_valid, 1);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        settle();
        chk_idle("abort_done");

        // Reset mid-job at idx=7.
        start_to_idx(5'd10, 7);
        reset = 1'b1;
        tick();
        settle();
        chk_idle("reset_mid");
        chk("reset_mid.mode_q", mode_q, 0);
        reset = 1'b0;
        tick();
        run_job(1'b0, 5'd3, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
